// File: rtl/mem_responder.sv
// Word-addressed memory responder: RAM plus MMIO block (TX FIFO, cycle counter, halt register).
// Reads are combinational; writes commit at the rising edge and are ignored once halted.
module mem_responder #(
  parameter int unsigned MEM_WORDS = 4096,
  parameter string       INIT_FILE = "",
  parameter int unsigned TX_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        halted,
  output logic [7:0]  exit_code,
  output logic        bus_error
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned PW = $clog2(TX_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] TxDepthC = CW'(TX_DEPTH);

  // Word indices of the MMIO registers (base 0x8000_0000)
  localparam logic [1:0] RegTxData = 2'd0;
  localparam logic [1:0] RegStatus = 2'd1;
  localparam logic [1:0] RegCycles = 2'd2;
  localparam logic [1:0] RegHalt   = 2'd3;

  logic [31:0]   mem_q [MEM_WORDS];
  logic [7:0]    fifo_q [TX_DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [31:0]   cycles_q, cycles_d;
  logic          halted_q, halted_d;
  logic [7:0]    exit_code_q, exit_code_d;
  logic          bus_error_q, bus_error_d;

  logic ram_sel, mmio_sel, unmapped;
  logic wr_en;
  logic push_req, push_ok, pop;
  logic fifo_full, fifo_empty;

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^address[1:0];

  // Address decode and write qualification
  always_comb begin
    ram_sel    = (address[31:2] < 30'(MEM_WORDS));
    mmio_sel   = (address[31:4] == 28'h800_0000);
    unmapped   = !ram_sel && !mmio_sel;
    // A write in the same cycle as reset must not commit anywhere, RAM included
    wr_en      = we && !halted_q && !reset;
    fifo_full  = (count_q == TxDepthC);
    fifo_empty = (count_q == '0);
    pop        = !fifo_empty && tx_ready;
    push_req   = wr_en && mmio_sel && (address[3:2] == RegTxData);
    push_ok    = push_req && (!fifo_full || pop);
  end

  // Next-state for FIFO pointers, flags, counter and halt register
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    cycles_d    = cycles_q + 32'd1;
    halted_d    = halted_q;
    exit_code_d = exit_code_q;
    bus_error_d = bus_error_q | unmapped;

    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (push_ok && !pop) count_d = count_q + CW'(1);
    else if (!push_ok && pop) count_d = count_q - CW'(1);
    if (push_req && !push_ok) overflow_d = 1'b1;

    if (wr_en && mmio_sel) begin
      unique case (address[3:2])
        RegStatus: if (data_in[2]) overflow_d = 1'b0;
        RegCycles: cycles_d = '0;
        RegHalt: begin
          halted_d    = 1'b1;
          exit_code_d = data_in[7:0];
        end
        default: ;
      endcase
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      cycles_q    <= '0;
      halted_q    <= 1'b0;
      exit_code_q <= '0;
      bus_error_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      cycles_q    <= cycles_d;
      halted_q    <= halted_d;
      exit_code_q <= exit_code_d;
      bus_error_q <= bus_error_d;
    end
  end

  // RAM write port; contents are not reset
  always_ff @(posedge clk) begin
    if (wr_en && ram_sel) mem_q[address[AW+1:2]] <= data_in;
  end

  // FIFO storage; only accepted pushes land
  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wr_ptr_q] <= data_in[7:0];
  end

  // Combinational read mux and output drive
  always_comb begin
    data_out = '0;
    if (ram_sel) begin
      data_out = mem_q[address[AW+1:2]];
    end else if (mmio_sel) begin
      unique case (address[3:2])
        RegTxData: data_out = '0;
        RegStatus: data_out = {16'b0, 8'(count_q), 5'b0, overflow_q, fifo_empty, fifo_full};
        RegCycles: data_out = cycles_q;
        RegHalt:   data_out = {23'b0, halted_q, exit_code_q};
        default:   data_out = '0;
      endcase
    end
    tx_valid  = !fifo_empty;
    tx_data   = fifo_empty ? 8'h00 : fifo_q[rd_ptr_q];
    halted    = halted_q;
    exit_code = exit_code_q;
    bus_error = bus_error_q;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder.
module tb_mem_responder;

  localparam logic [31:0] ATx   = 32'h8000_0000;
  localparam logic [31:0] ASt   = 32'h8000_0004;
  localparam logic [31:0] ACyc  = 32'h8000_0008;
  localparam logic [31:0] AHalt = 32'h8000_000C;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        halted;
  logic [7:0]  exit_code;
  logic        bus_error;

  int total = 0;
  int bad   = 0;

  mem_responder #(
    .MEM_WORDS(4096),
    .INIT_FILE(""),
    .TX_DEPTH (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .address  (address),
    .data_in  (data_in),
    .data_out (data_out),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .halted   (halted),
    .exit_code(exit_code),
    .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    address = a;
    data_in = d;
    we      = 1'b1;
    step();
    we      = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(tag, data_out, exp);
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; address = 32'h0; data_in = 32'h0; tx_ready = 1'b0;
    step();
    step();
    check("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    check("rst_tx_data", {24'b0, tx_data}, 32'h0);
    check("rst_halted", {31'b0, halted}, 32'h0);
    check("rst_exit_code", {24'b0, exit_code}, 32'h0);
    check("rst_bus_error", {31'b0, bus_error}, 32'h0);

    // Cycle counter: 10 edges after reset release
    reset = 1'b0;
    for (int i = 0; i < 10; i++) step();
    rd("cycles_10", ACyc, 32'd10);
    wr(ACyc, 32'h0);
    rd("cycles_after_clear0", ACyc, 32'd0);
    step(); rd("cycles_plus1", ACyc, 32'd1);
    step(); rd("cycles_plus2", ACyc, 32'd2);
    step(); rd("cycles_plus3", ACyc, 32'd3);

    // RAM round trip, byte offset ignored
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd("ram_rd_10", 32'h0000_0010, 32'hDEAD_BEEF);
    rd("ram_rd_13", 32'h0000_0013, 32'hDEAD_BEEF);
    wr(32'h0000_0000, 32'hCAFE_F00D);
    rd("ram_rd_0", 32'h0000_0000, 32'hCAFE_F00D);
    check("ram_bus_error", {31'b0, bus_error}, 32'h0);

    // FIFO fill with one overflowing push
    rd("status_empty", ASt, 32'h0000_0002);
    for (int i = 0; i < 9; i++) wr(ATx, 32'h41 + i);
    rd("status_full_ovf", ASt, 32'h0000_0805);
    rd("txdata_read", ATx, 32'h0);
    check("fill_tx_valid", {31'b0, tx_valid}, 32'h1);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("drain_byte%0d", i), {24'b0, tx_data}, 32'h41 + i);
      step();
    end
    tx_ready = 1'b0;
    check("drained_tx_valid", {31'b0, tx_valid}, 32'h0);
    check("drained_tx_data", {24'b0, tx_data}, 32'h0);
    rd("status_drained", ASt, 32'h0000_0006);
    wr(ASt, 32'h0000_0004);
    rd("status_ovf_cleared", ASt, 32'h0000_0002);

    // Full FIFO: pop and push in the same cycle
    for (int i = 0; i < 8; i++) wr(ATx, 32'h61 + i);
    rd("status_full", ASt, 32'h0000_0801);
    tx_ready = 1'b1;
    wr(ATx, 32'h5A);
    tx_ready = 1'b0;
    rd("status_full_swap", ASt, 32'h0000_0801);
    tx_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      #1;
      check($sformatf("swap_byte%0d", i), {24'b0, tx_data}, 32'h62 + i);
      step();
    end
    #1;
    check("swap_last_5a", {24'b0, tx_data}, 32'h5A);
    step();
    tx_ready = 1'b0;
    check("swap_empty", {31'b0, tx_valid}, 32'h0);

    // Unmapped read
    rd("unmapped_data", 32'h4000_0000, 32'h0);
    step();
    check("unmapped_bus_error", {31'b0, bus_error}, 32'h1);

    // Load a few bytes, then halt
    for (int i = 0; i < 3; i++) wr(ATx, 32'h71 + i);
    wr(AHalt, 32'h0000_0003);
    check("halted", {31'b0, halted}, 32'h1);
    check("exit_code", {24'b0, exit_code}, 32'h3);
    wr(32'h0000_0000, 32'h0000_1234);
    rd("ram_after_halt", 32'h0000_0000, 32'hCAFE_F00D);
    rd("halt_read", AHalt, 32'h0000_0103);
    wr(ATx, 32'h74);
    rd("status_halted_push", ASt, 32'h0000_0300);

    // Drain one byte, then reset asynchronously mid-drain
    tx_ready = 1'b1;
    step();
    check("mid_drain_byte", {24'b0, tx_data}, 32'h72);
    #2;
    reset = 1'b1;
    #1;
    check("mrst_tx_valid", {31'b0, tx_valid}, 32'h0);
    check("mrst_tx_data", {24'b0, tx_data}, 32'h0);
    check("mrst_halted", {31'b0, halted}, 32'h0);
    check("mrst_exit_code", {24'b0, exit_code}, 32'h0);
    check("mrst_bus_error", {31'b0, bus_error}, 32'h0);
    rd("mrst_status", ASt, 32'h0000_0002);
    tx_ready = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
